alu_share_ctrl: RTL and testbench

- Shares one 12-bit Q7.5 ALU (1-cycle latency, MAC accumulator cleared by any valid non-MAC op) between two requesters.
- Round-robin arbitration with MAC-chain locking: one requester's MAC sequence is never interleaved.
- Injects a flush op so that a new MAC chain never accumulates onto a previous chain.
- Routes ALU results back to the requester by tag.

---
 rtl/alu_share_pkg.sv | 22 ++
 rtl/alu_share_ctrl_rr_pick.sv | 33 +++
 rtl/alu_share_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// opcodes, controller states and result-routing tags.
package alu_share_pkg;

    localparam int DATA_W = 12;
    localparam int INST_W = 3;

    localparam logic [INST_W-1:0] OP_ADD   = 3'b000;
    localparam logic [INST_W-1:0] OP_SUB   = 3'b001;
    localparam logic [INST_W-1:0] OP_MUL   = 3'b010;
    localparam logic [INST_W-1:0] OP_MAC   = 3'b011;
    localparam logic [INST_W-1:0] OP_XNOR  = 3'b100;
    localparam logic [INST_W-1:0] OP_AND   = 3'b101;
    localparam logic [INST_W-1:0] OP_OR    = 3'b110;
    localparam logic [INST_W-1:0] OP_ABS   = 3'b111;
    // XNOR with zero operands is harmless and, being non-MAC, clears the accumulator.
    localparam logic [INST_W-1:0] OP_FLUSH = OP_XNOR;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
    typedef enum logic [1:0] {NONE, R0, R1, FLUSH} tag_t;

endpackage

// File: rtl/alu_share_ctrl_rr_pick.sv
// Two-way round-robin grant. Requests outside i_mask are ignored; the
// pointer moves to the side opposite the accepted one on every accept.
module alu_rr_pick (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic       r_ptr;
    logic [1:0] w_req;

    assign w_req = i_req & i_mask;

    always_comb begin
        o_grant = w_req;
        if (w_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // r_ptr = 1 favours requester 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 1-cycle ALU between two requesters: round-robin arbitration,
// MAC-chain locking, flush injection between chains, tag-based result routing.
module alu_share_ctrl
    import alu_share_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [INST_W-1:0] i_req0_inst,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic              i_req0_last,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [INST_W-1:0] i_req1_inst,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    input  logic              i_req1_last,
    output logic              o_alu_valid,
    output logic [INST_W-1:0] o_alu_inst,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic              i_alu_valid,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_alu_overflow,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_overflow,
    output logic              o_err,
    output logic [1:0]        o_dbg_state
);

    state_t            r_state, w_state_nxt;
    tag_t              r_tag1, r_tag2, w_tag_in;
    logic              r_last_mac;
    logic              r_alu_valid;
    logic [INST_W-1:0] r_alu_inst;
    logic [DATA_W-1:0] r_alu_a, r_alu_b;
    logic              r_rsp_valid, r_rsp_id, r_rsp_overflow, r_err;
    logic [DATA_W-1:0] r_rsp_data;

    logic [1:0]        w_mask, w_grant;
    logic              w_win, w_win_last, w_win_mac, w_any, w_flush, w_accept, w_rsp_hit;
    logic [INST_W-1:0] w_win_inst;
    logic [DATA_W-1:0] w_win_a, w_win_b;

    always_comb begin
        w_mask = 2'b11;
        case (r_state)
            LOCK0:   w_mask = 2'b01;
            LOCK1:   w_mask = 2'b10;
            default: w_mask = 2'b11;
        endcase
    end

    alu_rr_pick u_pick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    ({i_req1_valid, i_req0_valid}),
        .i_mask   (w_mask),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_win      = w_grant[1];
    assign w_win_inst = w_win ? i_req1_inst : i_req0_inst;
    assign w_win_a    = w_win ? i_req1_a    : i_req0_a;
    assign w_win_b    = w_win ? i_req1_b    : i_req0_b;
    assign w_win_last = w_win ? i_req1_last : i_req0_last;
    assign w_win_mac  = (w_win_inst == OP_MAC);
    assign w_any      = |w_grant;
    // A fresh chain right behind a MAC would accumulate onto it; burn one slot instead.
    assign w_flush    = w_any && (r_state == IDLE) && w_win_mac && r_last_mac;
    assign w_accept   = w_any && !w_flush;

    assign o_req0_ready = w_grant[0] && !w_flush;
    assign o_req1_ready = w_grant[1] && !w_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tag_in    = NONE;
        if (w_flush) begin
            w_tag_in = FLUSH;
        end else if (w_accept) begin
            w_tag_in    = w_win ? R1 : R0;
            w_state_nxt = IDLE;
            if (w_win_mac && !w_win_last) begin
                w_state_nxt = w_win ? LOCK1 : LOCK0;
            end
        end
    end

    assign w_rsp_hit = i_alu_valid && ((r_tag2 == R0) || (r_tag2 == R1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_mac     <= 1'b0;
            r_alu_valid    <= 1'b0;
            r_alu_inst     <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_tag1         <= NONE;
            r_tag2         <= NONE;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_overflow <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_alu_valid <= w_any;
            if (w_any) begin
                r_alu_inst <= w_flush ? OP_FLUSH : w_win_inst;
                r_alu_a    <= w_flush ? '0 : w_win_a;
                r_alu_b    <= w_flush ? '0 : w_win_b;
                r_last_mac <= w_accept && w_win_mac;
            end
            r_tag1      <= w_tag_in;
            r_tag2      <= r_tag1;
            r_rsp_valid <= w_rsp_hit;
            if (w_rsp_hit) begin
                r_rsp_id       <= (r_tag2 == R1);
                r_rsp_data     <= i_alu_data;
                r_rsp_overflow <= i_alu_overflow;
            end
            if (i_alu_valid != (r_tag2 != NONE)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_alu_valid    = r_alu_valid;
    assign o_alu_inst     = r_alu_inst;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_id       = r_rsp_id;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_err          = r_err;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: an ALU stub answers issued ops, and a request-level
// model predicts readies, ALU issues and routed responses cycle by cycle.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int AW = 59;  // {cyc[31:0], inst[2:0], a[11:0], b[11:0]}
    localparam int RW = 46;  // {cyc[31:0], id, data[11:0], ovf}

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst_n = 1'b0;
    logic              i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic [2:0]        i_req0_inst = '0, i_req1_inst = '0;
    logic [11:0]       i_req0_a = '0, i_req0_b = '0, i_req1_a = '0, i_req1_b = '0;
    logic              i_req0_last = 1'b0, i_req1_last = 1'b0;
    logic              o_req0_ready, o_req1_ready;
    logic              o_alu_valid;
    logic [2:0]        o_alu_inst;
    logic [11:0]       o_alu_a, o_alu_b;
    logic              i_alu_valid;
    logic [11:0]       i_alu_data;
    logic              i_alu_overflow;
    logic              o_rsp_valid, o_rsp_id, o_rsp_overflow, o_err;
    logic [11:0]       o_rsp_data;
    logic [1:0]        o_dbg_state;

    alu_share_ctrl dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_inst(i_req0_inst),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_last(i_req0_last),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_inst(i_req1_inst),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_last(i_req1_last),
        .o_alu_valid(o_alu_valid), .o_alu_inst(o_alu_inst), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_valid(i_alu_valid), .i_alu_data(i_alu_data), .i_alu_overflow(i_alu_overflow),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
        .o_rsp_overflow(o_rsp_overflow), .o_err(o_err), .o_dbg_state(o_dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- Q7.5 arithmetic and ALU stub ----------------
    function automatic logic [12:0] alu_calc(input logic [2:0] op, input logic [11:0] a,
                                             input logic [11:0] b, input logic [11:0] acc);
        logic [11:0] d;
        logic o;
        logic signed [23:0] sa, sb, p;
        sa = {{12{a[11]}}, a};
        sb = {{12{b[11]}}, b};
        p  = sa * sb;
        d  = '0;
        o  = 1'b0;
        case (op)
            OP_ADD:  begin d = a + b; o = (a[11] == b[11]) && (d[11] != a[11]); end
            OP_SUB:  begin d = a - b; o = (a[11] != b[11]) && (d[11] != a[11]); end
            OP_MAC:  d = acc + p[16:5];
            OP_XNOR: d = ~(a ^ b);
            default: d = '0;
        endcase
        return {o, d};
    endfunction

    logic        alu_v_q, alu_o_q, force_v = 1'b0;
    logic [11:0] alu_d_q, alu_acc;
    logic [12:0] stub_r;
    assign i_alu_valid    = alu_v_q | force_v;
    assign i_alu_data     = alu_d_q;
    assign i_alu_overflow = alu_o_q;

    always @(posedge clk) begin
        if (!i_rst_n) begin
            alu_v_q <= 1'b0; alu_d_q <= '0; alu_o_q <= 1'b0; alu_acc <= '0;
        end else begin
            alu_v_q <= o_alu_valid;
            if (o_alu_valid) begin
                stub_r  = alu_calc(o_alu_inst, o_alu_a, o_alu_b, alu_acc);
                alu_d_q <= stub_r[11:0];
                alu_o_q <= stub_r[12];
                alu_acc <= (o_alu_inst == OP_MAC) ? stub_r[11:0] : 12'h000;
            end
        end
    end

    // ---------------- model state and scoreboard ----------------
    int          n_cmp = 0, n_bad = 0;
    bit          chk_en = 1'b0;
    int          m_owner = -1;
    bit          m_ptr = 1'b0, m_last_mac = 1'b0;
    logic [11:0] m_acc = '0;
    logic [2:0]  m_alu_inst = '0;
    logic [11:0] m_alu_a = '0, m_alu_b = '0;
    int          err_cyc = 1 << 30;
    logic        exp_rdy0 = 1'b0, exp_rdy1 = 1'b0;
    logic [AW-1:0] exp_alu_q[$];
    logic [RW-1:0] exp_rsp_q[$];
    logic [RW-1:0] rsp_log[$];
    logic [32:0]   acc_log[$];
    int            flush_cnt = 0;

    bit          pend_v[2];
    logic [2:0]  pend_inst[2];
    logic [11:0] pend_a[2], pend_b[2];
    bit          pend_last[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Single compare process: registered outputs at +2, readies at +6.
    logic [AW-1:0] cmp_ea;
    logic [RW-1:0] cmp_er;
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            if (exp_alu_q.size() > 0) cmp_ea = exp_alu_q[0]; else cmp_ea = '0;
            if (exp_alu_q.size() > 0 && int'(cmp_ea[AW-1 -: 32]) == cyc) begin
                void'(exp_alu_q.pop_front());
                m_alu_inst = cmp_ea[26:24]; m_alu_a = cmp_ea[23:12]; m_alu_b = cmp_ea[11:0];
                chk("alu_issue", {o_alu_valid, o_alu_inst, o_alu_a, o_alu_b},
                    {1'b1, m_alu_inst, m_alu_a, m_alu_b});
            end else begin
                chk("alu_hold", {o_alu_valid, o_alu_inst, o_alu_a, o_alu_b},
                    {1'b0, m_alu_inst, m_alu_a, m_alu_b});
            end
            if (exp_rsp_q.size() > 0) cmp_er = exp_rsp_q[0]; else cmp_er = '0;
            if (exp_rsp_q.size() > 0 && int'(cmp_er[RW-1 -: 32]) == cyc) begin
                void'(exp_rsp_q.pop_front());
                chk("rsp", {o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow}, {1'b1, cmp_er[13:0]});
            end else begin
                chk("rsp_idle", o_rsp_valid, 1'b0);
            end
            chk("err", o_err, cyc >= err_cyc);
            if (o_rsp_valid) rsp_log.push_back({32'(cyc), o_rsp_id, o_rsp_data, o_rsp_overflow});
            if (o_alu_valid && o_alu_inst == OP_FLUSH && o_alu_a == 0 && o_alu_b == 0) flush_cnt++;
        end
        #4;
        if (chk_en) begin
            chk("ready", {o_req1_ready, o_req0_ready}, {exp_rdy1, exp_rdy0});
            if (o_req0_ready && i_req0_valid) acc_log.push_back({32'(cyc), 1'b0});
            if (o_req1_ready && i_req1_valid) acc_log.push_back({32'(cyc), 1'b1});
        end
    end

    // ---------------- driver + request-level model ----------------
    task automatic step(input bit rst);
        int cand;
        logic [12:0] r;
        logic [11:0] start;
        logic [AW-1:0] ta;
        logic [RW-1:0] tr;
        @(posedge clk);
        #4;
        if (rst) begin
            i_rst_n = 1'b0; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
            exp_rdy0 = 1'b0; exp_rdy1 = 1'b0;
            m_owner = -1; m_ptr = 1'b0; m_last_mac = 1'b0; m_acc = '0;
            m_alu_inst = '0; m_alu_a = '0; m_alu_b = '0; err_cyc = 1 << 30;
            while (exp_alu_q.size() > 0) begin
                ta = exp_alu_q[$];
                if (int'(ta[AW-1 -: 32]) > cyc) void'(exp_alu_q.pop_back()); else break;
            end
            while (exp_rsp_q.size() > 0) begin
                tr = exp_rsp_q[$];
                if (int'(tr[RW-1 -: 32]) > cyc) void'(exp_rsp_q.pop_back()); else break;
            end
            return;
        end
        i_rst_n = 1'b1;
        i_req0_valid = pend_v[0]; i_req0_inst = pend_inst[0]; i_req0_a = pend_a[0];
        i_req0_b = pend_b[0]; i_req0_last = pend_last[0];
        i_req1_valid = pend_v[1]; i_req1_inst = pend_inst[1]; i_req1_a = pend_a[1];
        i_req1_b = pend_b[1]; i_req1_last = pend_last[1];
        cand = -1;
        if (m_owner < 0) begin
            if (pend_v[0] && pend_v[1]) cand = int'(m_ptr);
            else if (pend_v[0]) cand = 0;
            else if (pend_v[1]) cand = 1;
        end else if (pend_v[m_owner]) begin
            cand = m_owner;
        end
        exp_rdy0 = 1'b0; exp_rdy1 = 1'b0;
        if (cand >= 0) begin
            if (m_owner < 0 && pend_inst[cand] == OP_MAC && m_last_mac) begin
                exp_alu_q.push_back({32'(cyc + 1), OP_FLUSH, 12'h000, 12'h000});
                m_last_mac = 1'b0;
            end else begin
                if (cand == 0) exp_rdy0 = 1'b1; else exp_rdy1 = 1'b1;
                exp_alu_q.push_back({32'(cyc + 1), pend_inst[cand], pend_a[cand], pend_b[cand]});
                start = (m_owner == cand) ? m_acc : 12'h000;
                r = alu_calc(pend_inst[cand], pend_a[cand], pend_b[cand], start);
                if (pend_inst[cand] == OP_MAC) m_acc = r[11:0];
                exp_rsp_q.push_back({32'(cyc + 3), 1'(cand), r[11:0], r[12]});
                m_last_mac = (pend_inst[cand] == OP_MAC);
                m_ptr = (cand == 0);
                m_owner = (pend_inst[cand] == OP_MAC && !pend_last[cand]) ? cand : -1;
                pend_v[cand] = 1'b0;
            end
        end
    endtask

    task automatic set_op(input int r, input logic [2:0] op, input logic [11:0] a,
                          input logic [11:0] b, input bit last);
        pend_v[r] = 1'b1; pend_inst[r] = op; pend_a[r] = a; pend_b[r] = b; pend_last[r] = last;
    endtask

    task automatic wait_acc(input int r);
        for (int k = 0; k < 20 && pend_v[r]; k++) step(1'b0);
        chk("accept_timeout", pend_v[r], 1'b0);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic clear_logs();
        rsp_log.delete(); acc_log.delete(); flush_cnt = 0;
    endtask

    function automatic logic [12:0] rsp_at(input int i);
        if (i < rsp_log.size()) return rsp_log[i][13:1];
        return '1;
    endfunction

    function automatic int log_cyc_rsp(input int i);
        if (i < rsp_log.size()) return int'(rsp_log[i][RW-1 -: 32]);
        return -100;
    endfunction

    function automatic int log_cyc_acc(input int i);
        if (i < acc_log.size()) return int'(acc_log[i][32:1]);
        return -100;
    endfunction

    function automatic logic acc_id(input int i);
        if (i < acc_log.size()) return acc_log[i][0];
        return 1'bx;
    endfunction

    initial begin
        int n0, n1;
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        step(1'b1); step(1'b1); step(1'b1);
        chk_en = 1'b1;
        chk("reset_outs", {o_req0_ready, o_req1_ready, o_alu_valid, o_alu_inst, o_alu_a, o_alu_b,
                           o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow, o_err, o_dbg_state}, 64'd0);

        // single ADD from req0
        clear_logs();
        set_op(0, OP_ADD, 12'h020, 12'h040, 1'b0);
        wait_acc(0);
        drain(5);
        chk("t1_rsp", {rsp_log.size() == 1, rsp_at(0), rsp_log.size() > 0 ? rsp_log[0][0] : 1'b1},
            {1'b1, 1'b0, 12'h060, 1'b0});
        chk("t1_latency", log_cyc_rsp(0) - log_cyc_acc(0), 3);

        // both valid, non-MAC: alternate from req0 after reset
        step(1'b1);
        clear_logs();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 12 && (n0 < 2 || n1 < 2 || pend_v[0] || pend_v[1]); k++) begin
            if (!pend_v[0] && n0 < 2) begin set_op(0, OP_SUB, 12'(16 + n0), 12'h001, 1'b0); n0++; end
            if (!pend_v[1] && n1 < 2) begin set_op(1, OP_ADD, 12'(32 + n1), 12'h002, 1'b0); n1++; end
            step(1'b0);
        end
        drain(5);
        chk("t2_grant_order", {acc_log.size() == 4, acc_id(0), acc_id(1), acc_id(2), acc_id(3)}, 5'b10101);
        chk("t2_rsp_ids", {rsp_log.size() == 4, rsp_at(0)[12], rsp_at(1)[12], rsp_at(2)[12],
                           rsp_at(3)[12]}, 5'b10101);

        // req0 MAC chain with req1 waiting
        clear_logs();
        set_op(0, OP_MAC, 12'h020, 12'h020, 1'b0);
        set_op(1, OP_ADD, 12'h001, 12'h002, 1'b0);
        step(1'b0);
        set_op(0, OP_MAC, 12'h040, 12'h020, 1'b1);
        step(1'b0);
        wait_acc(1);
        drain(5);
        chk("t3_order", {acc_log.size() == 3, acc_id(0), acc_id(1), acc_id(2)}, 4'b1001);
        chk("t3_rsp", {rsp_log.size() == 3, rsp_at(0), rsp_at(1), rsp_at(2)},
            {1'b1, 1'b0, 12'h020, 1'b0, 12'h060, 1'b1, 12'h003});

        // new chain from req1 right after req0's chain: one flush slot
        clear_logs();
        set_op(0, OP_MAC, 12'h020, 12'h020, 1'b1);
        wait_acc(0);
        set_op(1, OP_MAC, 12'h020, 12'h020, 1'b1);
        wait_acc(1);
        drain(5);
        chk("t4_flush_cnt", flush_cnt, 1);
        chk("t4_gap", log_cyc_acc(1) - log_cyc_acc(0), 2);
        chk("t4_rsp", {rsp_log.size() == 2, rsp_at(0), rsp_at(1)}, {1'b1, 1'b0, 12'h020, 1'b1, 12'h020});

        // reset right after a locking MAC accept
        clear_logs();
        set_op(0, OP_MAC, 12'h020, 12'h020, 1'b0);
        wait_acc(0);
        step(1'b1);
        set_op(1, OP_ADD, 12'h003, 12'h004, 1'b0);
        step(1'b0);
        chk("t5_zero_outs", {o_alu_valid, o_alu_inst, o_alu_a, o_alu_b, o_rsp_valid, o_rsp_id,
                             o_rsp_data, o_rsp_overflow, o_err, o_dbg_state}, 64'd0);
        #1;
        chk("t5_req1_ready", o_req1_ready, 1'b1);
        wait_acc(1);
        drain(5);
        chk("t5_rsp", {rsp_log.size() == 1, rsp_at(0)}, {1'b1, 1'b1, 12'h007});

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend_v[r] && $urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 3))
                        0:       set_op(r, OP_ADD, 12'($urandom), 12'($urandom), 1'b0);
                        1:       set_op(r, OP_SUB, 12'($urandom), 12'($urandom), 1'b0);
                        default: set_op(r, OP_MAC, 12'($urandom), 12'($urandom), $urandom_range(0, 2) == 0);
                    endcase
                end
            end
            step(1'b0);
        end
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        drain(8);

        // spurious ALU valid with nothing in flight
        step(1'b0);
        force_v = 1'b1;
        err_cyc = cyc + 1;
        step(1'b0);
        force_v = 1'b0;
        drain(4);
        chk("t6_err_held", o_err, 1'b1);
        step(1'b1);
        drain(3);
        chk("t6_err_cleared", o_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
